// File: rtl/data_mem_responder_if.sv
// Load/store port bundle between the processor and the data-memory responder.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request and the response channel.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Requester side (processor load/store unit)
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Responder side (data memory)
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory answering one load/store at a time.
// Latency: acceptance to resp_valid is LATENCY cycles; LATENCY+2 cycles per request back to back.
// Backpressure: req_ready low while a request is in flight; response held stable until resp_ready.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [AW-1:0] idx;
  logic          err_c;
  logic          commit;
  logic          mem_we;
  logic [31:0]   rd_word [DEPTH];

  // Word index and legality of the latched request; out-of-range requests never touch storage.
  assign idx    = addr_q[AW+1:2];
  assign err_c  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
  assign commit = (state == BUSY) && (cnt == 4'd0);
  // Gating with rst keeps a store from landing on an edge where reset is held.
  assign mem_we = rst && commit && wr_q && !err_c;

  // Storage: each word powers up holding its own index and is never cleared by reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] word_q = 32'(g);

    // Commit-edge store into this word
    always_ff @(posedge clk) begin
      if (mem_we && (idx == AW'(g))) word_q <= wdata_q;
    end

    assign rd_word[g] = word_q;
  end

  // Request/response FSM with all handshake outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      wr_q           <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            wr_q          <= bus.req_write;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            cnt           <= 4'(LATENCY - 1);
            bus.req_ready <= 1'b0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            // Commit edge: error and store responses carry zero data
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= err_c;
            bus.resp_rdata <= (!err_c && !wr_q) ? rd_word[idx] : 32'd0;
            state          <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 and a LATENCY=1 instance share one clock.
// Latency: checks acceptance-to-response timing and stream throughput.
// Backpressure: holds resp_ready low and checks the response stays frozen.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;

  data_mem_responder_if a ();
  data_mem_responder_if b ();

  data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(a));
  data_mem_responder #(.DEPTH(128), .LATENCY(1)) dut_b (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int cyc_b  = 0;
  int done_b = 0;

  // Expected responses, {err, rdata}
  logic [32:0] qa[$];
  logic [32:0] qb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_b <= cyc_b + 1;

  // Scoreboard for instance A: compare at the cycle a response is consumed
  always @(negedge clk) begin
    if (a.resp_valid && a.resp_ready) begin
      if (qa.size() == 0) check("a_unexpected_resp", 32'd1, 32'd0);
      else begin
        logic [32:0] e;
        e = qa.pop_front();
        check("a_rdata", a.resp_rdata, e[31:0]);
        check("a_err", {31'd0, a.resp_err}, {31'd0, e[32]});
      end
    end
  end

  // Scoreboard for instance B
  always @(negedge clk) begin
    if (b.resp_valid && b.resp_ready) begin
      if (qb.size() == 0) check("b_unexpected_resp", 32'd1, 32'd0);
      else begin
        logic [32:0] e;
        e = qb.pop_front();
        check("b_rdata", b.resp_rdata, e[31:0]);
        check("b_err", {31'd0, b.resp_err}, {31'd0, e[32]});
        done_b++;
      end
    end
  end

  // One request on instance A; caller is off the rising edge. hold>0 stalls the response.
  task automatic req_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [32:0] exp, input int hold);
    int k;
    logic [32:0] snap;
    qa.push_back(exp);
    a.req_valid = 1'b1;
    a.req_write = wr;
    a.req_addr  = addr;
    a.req_wdata = wd;
    k = 0;
    while (!a.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("a_accept_timeout", 32'(k), 32'd0);
    @(posedge clk);  // acceptance edge E0
    #1;
    a.req_valid    = 1'b0;
    a.req_write    = 1'($urandom);
    a.req_addr     = $urandom;
    a.req_wdata    = $urandom;
    a.resp_ready   = (hold == 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check("a_busy_req_ready", {31'd0, a.req_ready}, 32'd0);
    end while (!a.resp_valid && k < 40);
    check("a_latency", 32'(k - 1), 32'd2);
    if (hold > 0) begin
      snap = {a.resp_err, a.resp_rdata};
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (i == 1) begin
          a.req_valid = 1'b1;
          a.req_write = 1'b1;
          a.req_addr  = 32'h4;
          a.req_wdata = 32'h0000_0BAD;
        end
        if (i == 2) a.req_valid = 1'b0;
        @(negedge clk);
        check("a_hold_valid", {31'd0, a.resp_valid}, 32'd1);
        check("a_hold_rdata", a.resp_rdata, snap[31:0]);
        check("a_hold_err", {31'd0, a.resp_err}, {31'd0, snap[32]});
        check("a_hold_req_ready", {31'd0, a.req_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      a.resp_ready = 1'b1;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (a.resp_valid && k < 40);
    check("a_consume_timeout", 32'(k >= 40), 32'd0);
    check("a_idle_req_ready", {31'd0, a.req_ready}, 32'd1);
    check("a_idle_rdata", a.resp_rdata, 32'd0);
    check("a_idle_err", {31'd0, a.resp_err}, 32'd0);
  endtask

  initial begin
    int k;
    int start;
    rst = 1'b0;
    a.req_valid = 1'b0; a.req_write = 1'b0; a.req_addr = '0; a.req_wdata = '0; a.resp_ready = 1'b1;
    b.req_valid = 1'b0; b.req_write = 1'b0; b.req_addr = '0; b.req_wdata = '0; b.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, a.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, a.resp_valid}, 32'd0);
    check("rst_resp_rdata", a.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, a.resp_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic load, misaligned store must not disturb word 8, range and alignment errors
    req_a(1'b0, 32'h10,  32'h0, {1'b0, 32'd4}, 0);
    req_a(1'b1, 32'h22,  32'h1234_5678, {1'b1, 32'd0}, 0);
    req_a(1'b0, 32'h20,  32'h0, {1'b0, 32'd8}, 0);
    req_a(1'b0, 32'h22,  32'h0, {1'b1, 32'd0}, 0);
    req_a(1'b0, 32'h200, 32'h0, {1'b1, 32'd0}, 0);
    req_a(1'b1, 32'h200, 32'hFFFF_FFFF, {1'b1, 32'd0}, 0);
    req_a(1'b0, 32'h0,   32'h0, {1'b0, 32'd0}, 0);
    req_a(1'b0, 32'h1FC, 32'h0, {1'b0, 32'd127}, 0);
    req_a(1'b0, 32'h8000_0000, 32'h0, {1'b1, 32'd0}, 0);

    // Store then load back; neighbour untouched
    req_a(1'b1, 32'h20, 32'hDEAD_BEEF, {1'b0, 32'd0}, 0);
    req_a(1'b0, 32'h20, 32'h0, {1'b0, 32'hDEAD_BEEF}, 0);
    req_a(1'b0, 32'h24, 32'h0, {1'b0, 32'd9}, 0);

    // Backpressure with an ignored store pulse to word 1
    req_a(1'b0, 32'h40, 32'h0, {1'b0, 32'd16}, 5);
    req_a(1'b0, 32'h4,  32'h0, {1'b0, 32'd1}, 0);

    // Reset while the store is still before its commit edge
    a.req_valid = 1'b1; a.req_write = 1'b1; a.req_addr = 32'h30; a.req_wdata = 32'h55;
    @(posedge clk);
    #1;
    a.req_valid = 1'b0;
    @(negedge clk);
    check("mid_busy_req_ready", {31'd0, a.req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'd0, a.req_ready}, 32'd1);
    check("mid_rst_resp_valid", {31'd0, a.resp_valid}, 32'd0);
    check("mid_rst_resp_rdata", a.resp_rdata, 32'd0);
    check("mid_rst_resp_err", {31'd0, a.resp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_a(1'b0, 32'h30, 32'h0, {1'b0, 32'd12}, 0);

    // LATENCY=1 instance: four loads streamed with resp_ready tied high
    @(posedge clk);
    #1;
    start = cyc_b;
    for (int n = 0; n < 4; n++) begin
      b.req_addr  = 32'(n * 8 + 4);
      b.req_write = 1'b0;
      b.req_valid = 1'b1;
      qb.push_back({1'b0, 32'(n * 2 + 1)});
      k = 0;
      while (!b.req_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k >= 20) check("b_accept_timeout", 32'(k), 32'd0);
      @(posedge clk);
      #1;
      if (n == 0) begin
        @(negedge clk);
        check("b_first_busy_valid", {31'd0, b.resp_valid}, 32'd0);
        @(negedge clk);
        check("b_first_lat1_valid", {31'd0, b.resp_valid}, 32'd1);
      end
    end
    b.req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(done_b == 4 && !b.resp_valid) && k < 40);
    check("b_stream_cycles", 32'(cyc_b - start), 32'd12);

    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that sits on the far side of the processor's load/store port and replaces the zero-latency data array. It accepts one word-sized read or write request at a time through a valid/ready handshake, waits a fixed access latency, commits the access, and returns a response through a second valid/ready handshake. Misaligned or out-of-range requests complete with an error flag and leave memory unchanged.

## Interface
- DEPTH, 128, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH-4
- LATENCY, 2, cycles spent in BUSY per request; legal range 1..15
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response this cycle
- resp_rdata  output  32  load data; 0 for stores and errors
- resp_err  output  1  request was misaligned or out of range

## Operation
- States: IDLE, BUSY, RESP. Reset state IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- Storage: DEPTH x 32 array, word index = req_addr[31:2]. Contents initialise to word i = i at simulation start. Reset does not clear contents.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write, addr and wdata; load counter with LATENCY-1; go to BUSY. req_* changes after acceptance have no effect.
- BUSY: req_ready=0. Each edge decrements the counter. The edge where the counter is 0 is the commit edge, and the state goes to RESP.
- Commit edge:
  - err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH).
  - Store without error: write array.
  - Load without error: register array word into resp_rdata.
  - Otherwise: resp_rdata=0, no array write.
  - resp_err <= err.
- RESP: resp_valid=1, and resp_rdata/resp_err stay stable while resp_ready=0. On resp_valid&&resp_ready, go to IDLE; resp_valid, resp_rdata and resp_err clear to 0 on that edge.
- Only one outstanding request. No request is accepted in BUSY or RESP.
- Error requests take the same latency as legal ones.
- Reset asserted mid-operation: immediate return to IDLE with outputs at their reset values.
  - Before the commit edge: the pending store is discarded and memory is unchanged.
  - After the commit edge: the store remains.

## Timing
- Acceptance at edge E0. resp_valid is high from E0+LATENCY.
- Response consumed at edge E1 (E1 ≥ E0+LATENCY). req_ready is high from E1, so the earliest next acceptance is at edge E1+1.
- Back-to-back throughput with resp_ready tied high: one request per LATENCY+2 cycles.
- Store visibility: a load accepted after the store's response was consumed returns the new data.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then load from 0x10 with LATENCY=2: req_ready=1 after reset. Response appears 2 cycles after acceptance with resp_rdata=4, resp_err=0.
- Store 0xDEADBEEF to 0x20, then load from 0x20: the load returns 0xDEADBEEF and word 9 is untouched (still 9).
- Load 0x22 (misaligned), then load 0x200 (index 128 ≥ DEPTH): each gives resp_err=1 and resp_rdata=0. A store to 0x22 leaves word 8 = 8.
- Backpressure: hold resp_ready=0 for 5 cycles during RESP. resp_valid, resp_rdata and resp_err stay constant, req_ready=0, and a req_valid pulse is ignored. Raise resp_ready: return to IDLE and accept the next request one cycle later.
- Reset mid-op: store 0x55 to 0x30, deassert rst for one cycle while in BUSY before the commit edge. All outputs return to reset values immediately, and a subsequent load of 0x30 returns 12.
- LATENCY=1 build: accept-to-resp_valid is 1 cycle. With resp_ready tied high, a stream of 4 loads completes in 12 cycles.
